// File: rtl/uart_pkg.sv
// Shared UART definitions: link timing defaults and the receiver state encoding.
// Used by uart_rx_sampler and by the uartTX transmitter so both ends agree on bit timing.
package uart_pkg;

    localparam int unsigned UART_CLKS_PER_BIT = 8;
    localparam int unsigned UART_DATA_BITS    = 8;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK
    } uart_rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous, idle-high input; both flops reset to 1.
module uart_sync2 (
    input  logic clk,
    input  logic nrst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_sampler.sv
// Mid-bit sampling UART receiver (start, DATA_BITS LSB-first, optional even parity, stop).
// Define UART_RX_PARITY_EN to compile in the parity bit and a live parity_err output.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int unsigned DATA_BITS    = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 rcv,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned BW = $clog2(DATA_BITS + 1);

    logic                 rx_s;
    uart_rx_state_t       state_q, state_d;
    logic [CW-1:0]        cyc_q, cyc_d;
    logic [BW-1:0]        cnt_q, cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] data_d;
    logic                 rcv_d, ferr_d, perr_d, busy_d;
    logic                 tick;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_q, par_bad_d;
`endif

    uart_sync2 u_sync (
        .clk  (clk),
        .nrst (nrst),
        .d    (rx),
        .q    (rx_s)
    );

    // Cycle counter is reloaded on each state entry; a sample is due when it reaches zero.
    assign tick = (cyc_q == '0);

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        data_d  = data_out;
        rcv_d   = 1'b0;
        ferr_d  = 1'b0;
        perr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
`endif
        case (state_q)
            RX_IDLE: begin
                if (!rx_s) begin
                    state_d = RX_START;
                    cyc_d   = CW'(CLKS_PER_BIT / 2 - 1);
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                if (!tick) begin
                    cyc_d = cyc_q - CW'(1);
                end else if (!rx_s) begin
                    state_d = RX_DATA;
                    cyc_d   = CW'(CLKS_PER_BIT - 1);
                end else begin
                    state_d = RX_IDLE;
                end
            end
            RX_DATA: begin
                if (!tick) begin
                    cyc_d = cyc_q - CW'(1);
                end else begin
                    shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
                    cyc_d   = CW'(CLKS_PER_BIT - 1);
                    if (cnt_q == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_d = RX_PARITY;
`else
                        state_d = RX_STOP;
`endif
                    end else begin
                        cnt_d = cnt_q + BW'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            RX_PARITY: begin
                if (!tick) begin
                    cyc_d = cyc_q - CW'(1);
                end else begin
                    par_bad_d = (^shreg_q) ^ rx_s;
                    cyc_d     = CW'(CLKS_PER_BIT - 1);
                    state_d   = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                if (!tick) begin
                    cyc_d = cyc_q - CW'(1);
                end else if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                    if (par_bad_q) begin
                        perr_d = 1'b1;
                    end else begin
                        data_d = shreg_q;
                        rcv_d  = 1'b1;
                    end
`else
                    data_d = shreg_q;
                    rcv_d  = 1'b1;
`endif
                    state_d = RX_IDLE;
                end else begin
                    ferr_d  = 1'b1;
                    state_d = RX_BREAK;
                end
            end
            RX_BREAK: begin
                if (rx_s) begin
                    state_d = RX_IDLE;
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
        // Busy also covers the result-pulse cycle, after which IDLE is visible.
        busy_d = (state_d != RX_IDLE) | rcv_d | ferr_d | perr_d;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= RX_IDLE;
            cyc_q      <= '0;
            cnt_q      <= '0;
            shreg_q    <= '0;
            data_out   <= '0;
            rcv        <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            data_out   <= data_d;
            rcv        <= rcv_d;
            frame_err  <= ferr_d;
            parity_err <= perr_d;
            busy       <= busy_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q  <= par_bad_d;
`endif
        end
    end

endmodule

// File: doc/uart_rx_sampler.md
# uart_rx_sampler

Mid-bit sampling UART receiver: the receive end of the team's 8N1 serial link whose transmitter is `uartTX`. It takes the asynchronous `rx` line, synchronises it, validates the start bit, and shifts in 8 data bits LSB-first. It checks the stop bit and delivers each byte as a one-cycle `rcv` strobe, with framing (and optional parity) errors flagged. It sits between the pad or loopback wire and the byte consumer.

## Interface
- `CLKS_PER_BIT`, default 8: clock cycles per serial bit. Must be an even integer ≥ 4 and must match the transmitter.
- `DATA_BITS`, default 8: payload bits per frame.
- `clk` in 1: sole clock; all state changes on its rising edge.
- `nrst` in 1: reset, asynchronous and active-low.
- `rx` in 1: serial line. Idle high, asynchronous to `clk`.
- `data_out` out DATA_BITS: last good byte. Holds its value until the next good frame.
- `rcv` out 1: one-cycle pulse; `data_out` is valid in the same cycle.
- `frame_err` out 1: one-cycle pulse when the stop bit is sampled low.
- `parity_err` out 1: one-cycle pulse on parity mismatch. Tied 0 without the parity macro.
- `busy` out 1: high in every state except IDLE.

## Operation
- `rx` passes through a 2-flop synchroniser (reset value 1) to give `rx_s`. All decisions use `rx_s` only.
- States: IDLE, START, DATA, PARITY (macro only), STOP, BREAK.
- IDLE: when `rx_s == 0`, go to START and clear the bit counter `cnt`.
- START: count `CLKS_PER_BIT/2` cycles, then sample `rx_s`.
  - Sample 0: go to DATA.
  - Sample 1 (glitch): go to IDLE. No outputs change.
- DATA: every `CLKS_PER_BIT` cycles, sample `rx_s` into `shreg` (LSB first, shift right into the MSB). After `DATA_BITS` samples, go to PARITY (macro) or STOP.
- PARITY: wait `CLKS_PER_BIT` cycles, then sample.
  - Expected value is even parity: XOR of data bits equals the parity bit.
  - The result is latched and reported at STOP.
- STOP: wait `CLKS_PER_BIT` cycles, then sample.
  - Sample 1 and parity OK: load `data_out <= shreg`, pulse `rcv`, go to IDLE.
  - Sample 1 and parity bad: pulse `parity_err`. `data_out` unchanged, no `rcv`. Go to IDLE.
  - Sample 0: pulse `frame_err`. `data_out` unchanged, no `rcv`. Go to BREAK.
- BREAK: stay until `rx_s == 1`, then go to IDLE. A held-low line gives exactly one `frame_err` and no spurious frames.
- Counters: the cycle counter width is `$clog2(CLKS_PER_BIT)`; the bit counter width is `$clog2(DATA_BITS+1)`. Both wrap-safe: they are reloaded on every state entry and never free-run.
- Reset: any state goes to IDLE immediately. A frame in progress is discarded with no pulses.

## Timing
- Reset values: `data_out = 0`, `rcv = 0`, `frame_err = 0`, `parity_err = 0`, `busy = 0`, `rx_s = 1`.
- Reference edge E0: the first rising `clk` edge at which the `rx` pin is low.
  - `rx_s` goes low at E0+1.
  - State is START from E0+2.
- Mid-bit sample k, with k = 0 for start: taken at E0+2+`CLKS_PER_BIT/2`+k·`CLKS_PER_BIT`.
- `rcv` / `frame_err` / `parity_err` are high for exactly one cycle after the stop-bit sample.
  - Stop-bit sample is k = `DATA_BITS`+1, or `DATA_BITS`+2 with parity.
  - With defaults, `rcv` rises 2+4+72 = 78 cycles after E0.
- `busy` is high from E0+2 through the pulse cycle. IDLE is re-entered the next cycle.
- Back-to-back frames: a start bit that begins right after the stop bit is accepted with no gap cycle required.
- The three pulses are mutually exclusive. `rcv` and `data_out` update in the same cycle.

## Configuration
- `UART_RX_PARITY_EN` defined: the PARITY state is compiled in. The frame is start, 8 data, even parity, stop. `parity_err` is live.
- Not defined: the frame is 8N1, the PARITY state is absent, and `parity_err` is constant 0. The port list is identical in both builds.

## Structure
- Package `uart_pkg`:
  - `uart_rx_state_t` enum.
  - Default `CLKS_PER_BIT` constant, shared with `uartTX` so both ends agree.
  - `DATA_BITS` constant.
- Sub-module `uart_sync2`: parameterless 2-flop synchroniser with async active-low reset and reset value 1. Reusable for other async inputs.
- FSM, counters, and shift register live in `uart_rx_sampler`.

## Test plan
All scenarios use `CLKS_PER_BIT = 4` with `uartTX` looped back unless noted.
- Reset, then idle line high for 100 cycles → all outputs 0, `busy` 0.
- Send 0x4B, then 0x48 back-to-back → two `rcv` pulses, `data_out` = 0x4B then 0x48, no error pulses.
- Driven `rx` low for 1 cycle (less than half a bit) → no `rcv`, `busy` drops 0 within 5 cycles.
- Frame 0xA5 with stop bit forced 0, line held low 40 more cycles → one `frame_err`, `data_out` keeps its previous value, next valid frame 0x3C received.
- `nrst` pulsed low in the middle of data bit 4 → outputs return to reset values at once, no pulse; the following frame 0x81 is received correctly.
- With `UART_RX_PARITY_EN`, frame 0x07 with a wrong parity bit → `parity_err` pulse, no `rcv`. Same frame with the correct parity bit → `rcv`, `data_out` = 0x07.
